dsp_skid_stage: RTL



---
 rtl/dsp_pkg.sv | 23 ++
 rtl/dsp_skid_stage.sv | 112 +++++++++++
 2 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP slice: datapath width, occupancy width and
// the elastic-stage state type.
package dsp_pkg;

  localparam int DSP_DATA_W = 18;
  localparam int LEVEL_W    = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Occupancy of the elastic stage for a given state.
  function automatic logic [LEVEL_W-1:0] state_level(input skid_state_t s);
    case (s)
      ONE:     return LEVEL_W'(1);
      FULL:    return LEVEL_W'(2);
      default: return LEVEL_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/dsp_skid_stage.sv
// Two-entry elastic stage between a DSP result producer and its consumer.
// PIPE=1 gives a registered stage with a skid entry so in_ready is a flop;
// PIPE=0 collapses to wires.
//
// state | meaning
// ------+------------------------------------------------------------
// EMPTY | nothing held; out_valid=0, in_ready=1, level=0
// ONE   | M holds the head word; out_valid=1, in_ready=1, level=1
// FULL  | M holds head, S holds the next word; in_ready=0, level=2
module dsp_skid_stage
  import dsp_pkg::*;
#(
  parameter int DATA_W = DSP_DATA_W,
  parameter int PIPE   = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLR,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] level
);

  if (PIPE != 0) begin : g_pipe
    skid_state_t        state_q, state_d;
    logic [DATA_W-1:0]  m_q, m_d;
    logic [DATA_W-1:0]  s_q, s_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [LEVEL_W-1:0] level_q;
    logic               in_fire;
    logic               out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next state and storage updates; CLR wins over any fire this cycle.
    always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            m_d     = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_d = in_data;
          end else if (in_fire) begin
            s_d     = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            m_d     = s_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (CLR) begin
        state_d = EMPTY;
      end
    end

    // State and handshake flags; flags are decoded from the next state so
    // every output is a flop and in_ready never sees out_ready combinationally.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_q     <= EMPTY;
        in_ready_q  <= 1'b0;
        out_valid_q <= 1'b0;
        level_q     <= '0;
      end else begin
        state_q     <= state_d;
        in_ready_q  <= (state_d != FULL);
        out_valid_q <= (state_d != EMPTY);
        level_q     <= state_level(state_d);
      end
    end

    // Data holding registers; contents are meaningless while empty, so no reset.
    always_ff @(posedge CLK) begin
      m_q <= m_d;
      s_q <= s_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = m_q;
    assign level     = level_q;
  end else begin : g_pass
    logic unused_ctrl;

    assign unused_ctrl = ^{CLK, RST, CLR};
    assign out_valid   = in_valid;
    assign out_data    = in_data;
    assign in_ready    = out_ready;
    assign level       = '0;
  end

endmodule
